interrupt_acknowledge_sequencer: RTL

- Runs the 8259A INTA handshake between the priority resolver and the CPU data bus.
- Asserts INT to the CPU, counts INTA pulses, latches the acknowledged level and drives the vector bytes.
- Produces `acknowledge_interrupt` and the `end_of_acknowledge_sequence` pulse consumed by the OCW2/EOI stage and the in-service register.
- Sits directly upstream of the OCW2 block.

---
 rtl/interrupt_acknowledge_sequencer_pkg.sv | 28 ++
 rtl/interrupt_acknowledge_sequencer_inta_edge_detector.sv | 29 ++
 rtl/interrupt_acknowledge_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/interrupt_acknowledge_sequencer_pkg.sv
// Shared types, constants and level conversion helpers for the 8259A INTA sequencer.

package interrupt_acknowledge_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StPulse1,
      StPulse2,
      StPulse3
   } state_e;

   localparam logic [7:0] CallOpcode    = 8'hCD;
   localparam logic [2:0] SpuriousLevel = 3'd7;

   function automatic logic [2:0] bit2num(input logic [7:0] onehot);
      logic [2:0] num;
      num = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) num = 3'(i);
      end
      return num;
   endfunction

   function automatic logic [7:0] num2bit(input logic [2:0] num);
      return 8'd1 << num;
   endfunction

endpackage

// File: rtl/interrupt_acknowledge_sequencer_inta_edge_detector.sv
// Registers the synchronised INTA pin and flags its falling and rising edges.

module interrupt_acknowledge_sequencer_inta_edge_detector (
   input  logic clock,
   input  logic reset_n,
   input  logic inta_n,
   output logic fall,
   output logic rise
);

   logic inta_q;
   logic inta_d;

   always_comb begin
      inta_d = inta_n;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inta_q <= 1'b1;
      end else begin
         inta_q <= inta_d;
      end
   end

   assign fall = inta_q & ~inta_n;
   assign rise = ~inta_q & inta_n;

endmodule

// File: rtl/interrupt_acknowledge_sequencer.sv
// 8259A INTA handshake: raises INT, counts INTA pulses, latches the level and drives vector bytes.

module interrupt_acknowledge_sequencer
   import interrupt_acknowledge_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        interrupt_acknowledge_n,
   input  logic [7:0]  interrupt_request,
   input  logic        write_initial_command_word_1,
   input  logic        u8086_or_mcs80_config,
   input  logic        call_address_interval_4,
   input  logic [10:0] interrupt_vector_address,
   output logic        interrupt_to_cpu,
   output logic        latch_in_service,
   output logic [7:0]  acknowledge_interrupt,
   output logic        end_of_acknowledge_sequence,
   output logic        out_control_logic_data,
   output logic [7:0]  control_logic_data
);

   logic        fall;
   logic        rise;
   state_e      state_q, state_d;
   logic        int_q, int_d;
   logic        lis_q, lis_d;
   logic [7:0]  ack_q, ack_d;
   logic        eoa_q, eoa_d;
   logic        oe_q, oe_d;
   logic [7:0]  data_q, data_d;
   logic        mode_q, mode_d;
   logic        ci4_q, ci4_d;
   logic [10:0] iva_q, iva_d;
   logic [2:0]  lvl_q;
   logic [7:0]  ack_new;
   logic [7:0]  byte2;
   logic [7:0]  byte3;

   interrupt_acknowledge_sequencer_inta_edge_detector u_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .inta_n  (interrupt_acknowledge_n),
      .fall    (fall),
      .rise    (rise)
   );

   // An empty request at the first INTA is answered as spurious level 7.
   assign ack_new = (interrupt_request == 8'h00) ? num2bit(SpuriousLevel) : interrupt_request;
   assign lvl_q   = bit2num(ack_q);
   assign byte2   = mode_q ? {iva_q[10:6], lvl_q} :
                    ci4_q  ? {iva_q[2:0], lvl_q, 2'b00} :
                             {iva_q[2:1], lvl_q, 3'b000};
   assign byte3   = iva_q[10:3];

   always_comb begin
      state_d = state_q;
      int_d   = int_q;
      lis_d   = 1'b0;
      ack_d   = ack_q;
      eoa_d   = 1'b0;
      oe_d    = oe_q;
      data_d  = data_q;
      mode_d  = mode_q;
      ci4_d   = ci4_q;
      iva_d   = iva_q;

      unique case (state_q)
         StIdle: begin
            int_d  = |interrupt_request;
            ack_d  = 8'h00;
            oe_d   = 1'b0;
            data_d = 8'h00;
            if (fall) begin
               mode_d  = u8086_or_mcs80_config;
               ci4_d   = call_address_interval_4;
               iva_d   = interrupt_vector_address;
               ack_d   = ack_new;
               lis_d   = |interrupt_request;
               int_d   = 1'b0;
               oe_d    = ~u8086_or_mcs80_config;
               data_d  = u8086_or_mcs80_config ? 8'h00 : CallOpcode;
               state_d = StPulse1;
            end
         end
         StPulse1: begin
            if (rise) begin
               oe_d    = 1'b0;
               data_d  = 8'h00;
               state_d = StPulse2;
            end
         end
         StPulse2: begin
            if (fall) begin
               oe_d   = 1'b1;
               data_d = byte2;
            end else if (rise) begin
               oe_d   = 1'b0;
               data_d = 8'h00;
               if (mode_q) begin
                  eoa_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StPulse3;
               end
            end
         end
         StPulse3: begin
            if (fall) begin
               oe_d   = 1'b1;
               data_d = byte3;
            end else if (rise) begin
               oe_d    = 1'b0;
               data_d  = 8'h00;
               eoa_d   = 1'b1;
               state_d = StIdle;
            end
         end
      endcase

      // ICW1 re-initialises the controller mid-sequence without an end pulse.
      if (write_initial_command_word_1) begin
         state_d = StIdle;
         int_d   = 1'b0;
         lis_d   = 1'b0;
         ack_d   = 8'h00;
         eoa_d   = 1'b0;
         oe_d    = 1'b0;
         data_d  = 8'h00;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         int_q   <= 1'b0;
         lis_q   <= 1'b0;
         ack_q   <= 8'h00;
         eoa_q   <= 1'b0;
         oe_q    <= 1'b0;
         data_q  <= 8'h00;
         mode_q  <= 1'b0;
         ci4_q   <= 1'b0;
         iva_q   <= 11'h000;
      end else begin
         state_q <= state_d;
         int_q   <= int_d;
         lis_q   <= lis_d;
         ack_q   <= ack_d;
         eoa_q   <= eoa_d;
         oe_q    <= oe_d;
         data_q  <= data_d;
         mode_q  <= mode_d;
         ci4_q   <= ci4_d;
         iva_q   <= iva_d;
      end
   end

   assign interrupt_to_cpu            = int_q;
   assign latch_in_service            = lis_q;
   assign acknowledge_interrupt       = ack_q;
   assign end_of_acknowledge_sequence = eoa_q;
   assign out_control_logic_data      = oe_q;
   assign control_logic_data          = data_q;

endmodule
